// File: rtl/u712_transfer_term.sv
// Bus-cycle termination unit for 68040/68060: arbitrates TA/TBI/TEA across NCH
// decoded spaces, tracks line-burst beats and ends stalled cycles with TEA.
module u712_transfer_term #(
    parameter int NCH         = 4,
    parameter int TIMEOUT     = 255,
    parameter int BURST_BEATS = 4
) (
    input  logic           CLK40,
    input  logic           nRESET,
    input  logic           nTS,
    input  logic [1:0]     SIZ,
    input  logic [NCH-1:0] SPACE_SEL,
    input  logic [NCH-1:0] SRC_ACK,
    input  logic [NCH-1:0] BURST_OK,
    input  logic [NCH-1:0] SRC_ABORT,
    output wire            nTA,
    output wire            nTBI,
    output wire            nTEA,
    output logic           BUSY,
    output logic           TIMEOUT_ERR
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BTW = $clog2(BURST_BEATS);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [BTW-1:0] BEAT_LAST = BTW'(BURST_BEATS - 1);
    // Counting the current ack-less cycle, TIMEOUT is reached when the register holds TIMEOUT-1.
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t         state_q;
    logic [CHW-1:0] ch_q;
    logic           breq_q;
    logic           burst_q;
    logic [BTW-1:0] beat_q;
    logic [WDW-1:0] wd_q;

    logic           start_s;
    logic [CHW-1:0] start_ch_s;
    logic           active_s;
    logic           ack_s;
    logic           first_s;
    logic           burst_now_s;
    logic           final_s;
    logic           wd_fire_s;
    logic           ta_s;
    logic           tbi_s;
    logic           tea_s;
    logic           drive_s;

    function automatic logic [CHW-1:0] lowest_idx(input logic [NCH-1:0] sel);
        logic [CHW-1:0] idx;
        idx = {CHW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = CHW'(i);
            end
        end
        return idx;
    endfunction

    // Decode cycle start, acknowledge, burst decision and watchdog expiry.
    always_comb begin
        start_s     = 1'b0;
        start_ch_s  = lowest_idx(SPACE_SEL);
        active_s    = 1'b0;
        ack_s       = 1'b0;
        first_s     = 1'b0;
        burst_now_s = 1'b0;
        final_s     = 1'b0;
        wd_fire_s   = 1'b0;
        ta_s        = 1'b1;
        tbi_s       = 1'b1;
        tea_s       = 1'b1;
        drive_s     = 1'b0;
        start_s     = !nTS && (|SPACE_SEL);
        active_s    = (state_q == S_ACTIVE);
        drive_s     = (state_q != S_IDLE);
        ack_s       = active_s && SRC_ACK[ch_q];
        first_s     = (beat_q == {BTW{1'b0}});
        burst_now_s = breq_q && BURST_OK[ch_q] && !SRC_ABORT[ch_q];
        if (first_s) begin
            final_s = !burst_now_s;
        end else begin
            final_s = !burst_q || (beat_q == BEAT_LAST);
        end
        // An ack in the expiry cycle wins over the bus error.
        wd_fire_s = active_s && !ack_s && (wd_q == WD_LAST);
        ta_s      = !ack_s;
        tbi_s     = !(ack_s && first_s && (!BURST_OK[ch_q] || SRC_ABORT[ch_q]));
        tea_s     = !wd_fire_s;
    end

    // Termination FSM with channel latch, beat counter and saturating watchdog.
    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            ch_q    <= {CHW{1'b0}};
            breq_q  <= 1'b0;
            burst_q <= 1'b0;
            beat_q  <= {BTW{1'b0}};
            wd_q    <= {WDW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE, S_RELEASE: begin
                    if (start_s) begin
                        state_q <= S_ACTIVE;
                        ch_q    <= start_ch_s;
                        breq_q  <= (SIZ == 2'b11);
                        burst_q <= 1'b0;
                        beat_q  <= {BTW{1'b0}};
                        wd_q    <= {WDW{1'b0}};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (ack_s) begin
                        wd_q   <= {WDW{1'b0}};
                        beat_q <= beat_q + 1'b1;
                        if (first_s) begin
                            burst_q <= burst_now_s;
                        end
                        if (final_s) begin
                            state_q <= S_RELEASE;
                        end
                    end else if (wd_fire_s) begin
                        state_q <= S_RELEASE;
                    end else if (wd_q != WD_LAST) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign nTA         = drive_s ? ta_s  : 1'bz;
    assign nTBI        = drive_s ? tbi_s : 1'bz;
    assign nTEA        = drive_s ? tea_s : 1'bz;
    assign BUSY        = drive_s;
    assign TIMEOUT_ERR = wd_fire_s;

endmodule

// File: tb/tb_u712_transfer_term.sv
// Directed bench for u712_transfer_term: vector table plus hand-written timeout,
// tie and mid-burst reset sequences.
module tb_u712_transfer_term;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] PZ = 2'd2;
    localparam int NV = 26;

    typedef struct packed {
        logic       nts;
        logic [1:0] siz;
        logic [3:0] sel;
        logic [3:0] ack;
        logic [3:0] ok;
        logic [3:0] abort;
        logic [1:0] ta;
        logic [1:0] tbi;
        logic [1:0] tea;
        logic       busy;
        logic       terr;
    } vec_t;

    logic       CLK40;
    logic       nRESET;
    logic       nTS;
    logic [1:0] SIZ;
    logic [3:0] SPACE_SEL;
    logic [3:0] SRC_ACK;
    logic [3:0] BURST_OK;
    logic [3:0] SRC_ABORT;
    wire        nTA;
    wire        nTBI;
    wire        nTEA;
    logic       BUSY;
    logic       TIMEOUT_ERR;

    logic [1:0] ta_code;
    logic [1:0] tbi_code;
    logic [1:0] tea_code;

    int checks;
    int errors;
    int terr_pulses;
    vec_t tbl [NV];

    u712_transfer_term #(.NCH(4), .TIMEOUT(8), .BURST_BEATS(4)) dut (
        .CLK40      (CLK40),
        .nRESET     (nRESET),
        .nTS        (nTS),
        .SIZ        (SIZ),
        .SPACE_SEL  (SPACE_SEL),
        .SRC_ACK    (SRC_ACK),
        .BURST_OK   (BURST_OK),
        .SRC_ABORT  (SRC_ABORT),
        .nTA        (nTA),
        .nTBI       (nTBI),
        .nTEA       (nTEA),
        .BUSY       (BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    assign ta_code  = (nTA  === 1'bz) ? PZ : {1'b0, nTA};
    assign tbi_code = (nTBI === 1'bz) ? PZ : {1'b0, nTBI};
    assign tea_code = (nTEA === 1'bz) ? PZ : {1'b0, nTEA};

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    function automatic vec_t mk(input logic nts, input logic [1:0] siz, input logic [3:0] sel,
                                input logic [3:0] ack, input logic [3:0] ok, input logic [3:0] abort,
                                input logic [1:0] ta, input logic [1:0] tbi, input logic [1:0] tea,
                                input logic busy, input logic terr);
        vec_t v;
        v.nts = nts; v.siz = siz; v.sel = sel; v.ack = ack; v.ok = ok; v.abort = abort;
        v.ta = ta; v.tbi = tbi; v.tea = tea; v.busy = busy; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d (0=low 1=high 2=Z)", nm, id, act, exp);
        end
    endtask

    task automatic compare(input vec_t v, input int id);
        chk("nTA", id, ta_code, v.ta);
        chk("nTBI", id, tbi_code, v.tbi);
        chk("nTEA", id, tea_code, v.tea);
        chk("BUSY", id, {1'b0, BUSY}, {1'b0, v.busy});
        chk("TIMEOUT_ERR", id, {1'b0, TIMEOUT_ERR}, {1'b0, v.terr});
    endtask

    task automatic apply(input vec_t v);
        nTS = v.nts; SIZ = v.siz; SPACE_SEL = v.sel;
        SRC_ACK = v.ack; BURST_OK = v.ok; SRC_ABORT = v.abort;
    endtask

    // Called at posedge+1: drive one cycle, check mid-cycle, advance to next posedge+1.
    task automatic step(input vec_t v, input int id);
        apply(v);
        @(negedge CLK40);
        if (TIMEOUT_ERR === 1'b1) terr_pulses++;
        compare(v, id);
        @(posedge CLK40);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        terr_pulses = 0;

        // single non-burst read on CH1, ack in 4th ACTIVE cycle
        tbl[0]  = mk(1'b0, 2'b00, 4'b0010, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 2'b00, 4'b0000, 4'b0010, 4'b0000, 4'b0000, P0, P0, P1, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        // unselected transfer start
        tbl[7]  = mk(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        // line burst on CH2, foreign acks and SPACE_SEL changes ignored
        tbl[9]  = mk(1'b0, 2'b11, 4'b0100, 4'b0000, 4'b0100, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b0100, 4'b0000, P0, P1, P1, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 2'b11, 4'b0001, 4'b1011, 4'b0100, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b0100, 4'b0000, P0, P1, P1, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0100, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b0100, 4'b0000, P0, P1, P1, 1'b1, 1'b0);
        tbl[15] = mk(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0100, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b0100, 4'b0000, P0, P1, P1, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0100, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        // burst inhibited by abort, then back-to-back start in RELEASE selecting CH2
        tbl[19] = mk(1'b0, 2'b11, 4'b0100, 4'b0000, 4'b1111, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);
        tbl[20] = mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b1111, 4'b0100, P0, P0, P1, 1'b1, 1'b0);
        tbl[21] = mk(1'b0, 2'b00, 4'b1100, 4'b0000, 4'b1111, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[22] = mk(1'b1, 2'b00, 4'b0000, 4'b1000, 4'b1111, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[23] = mk(1'b1, 2'b00, 4'b0000, 4'b0100, 4'b1111, 4'b0000, P0, P1, P1, 1'b1, 1'b0);
        tbl[24] = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b0000, P1, P1, P1, 1'b1, 1'b0);
        tbl[25] = mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1111, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0);

        nRESET = 1'b0;
        apply(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0));
        repeat (3) @(posedge CLK40);
        @(negedge CLK40);
        compare(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 900);
        nRESET = 1'b1;
        @(posedge CLK40);
        #1;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], i);
        end

        // watchdog timeout on CH0: TEA in 8th ACTIVE cycle
        terr_pulses = 0;
        step(mk(1'b0, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 100);
        for (int k = 1; k <= 8; k++) begin
            step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1,
                    (k == 8) ? P0 : P1, 1'b1, (k == 8)), 100 + k);
        end
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0), 109);
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 110);
        chk("terr_pulse_count", 111, 2'(terr_pulses), 2'd1);

        // timeout tie: ack in the expiry cycle wins
        step(mk(1'b0, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 200);
        for (int k = 1; k <= 7; k++) begin
            step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0), 200 + k);
        end
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0001, 4'b0000, 4'b0000, P0, P0, P1, 1'b1, 1'b0), 208);
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, P1, P1, P1, 1'b1, 1'b0), 209);
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 210);

        // reset mid-burst releases the pins at once
        step(mk(1'b0, 2'b11, 4'b0100, 4'b0000, 4'b0100, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 300);
        step(mk(1'b1, 2'b11, 4'b0000, 4'b0100, 4'b0100, 4'b0000, P0, P1, P1, 1'b1, 1'b0), 301);
        apply(mk(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0100, 4'b0000, P1, P1, P1, 1'b1, 1'b0));
        #2;
        chk("BUSY_pre_reset", 302, {1'b0, BUSY}, 2'd1);
        nRESET = 1'b0;
        #1;
        compare(mk(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 303);
        @(posedge CLK40);
        #1;
        nRESET = 1'b1;
        step(mk(1'b1, 2'b00, 4'b0000, 4'b0100, 4'b0100, 4'b0000, PZ, PZ, PZ, 1'b0, 1'b0), 304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/u712_transfer_term.md
Name: u712_transfer_term

Overview:
- Parametrised 68040/68060 bus-cycle termination unit. Successor to the single-space TA/TBI generator.
- Arbitrates TA, TBI and TEA across NCH decoded address spaces.
- Tracks line-burst beats and runs a watchdog that ends stalled cycles with a bus error.
- Sits between the U712 address decoder / slave state machines and the CPU termination pins.

Parameters:
NCH, 4, number of termination sources (address spaces); 1..8
TIMEOUT, 255, ACTIVE cycles without an ack before TEA is asserted; >= 2
BURST_BEATS, 4, beats in a line burst; power of two, >= 2

Ports:
CLK40  input  1  system clock, all state updates on rising edge
nRESET  input  1  asynchronous active-low reset
nTS  input  1  CPU transfer start, active low, one cycle
SIZ  input  2  CPU transfer size; 2'b11 = line (burst) request
SPACE_SEL  input  NCH  decoded space select per source, active high
SRC_ACK  input  NCH  per-source data-ready pulse, one per beat, active high
BURST_OK  input  NCH  source can supply a full line burst
SRC_ABORT  input  NCH  source requests burst inhibit, sampled on first beat only (e.g. DMA interruption)
nTA  output  1  transfer acknowledge, tri-state
nTBI  output  1  transfer burst inhibit, tri-state
nTEA  output  1  transfer error acknowledge, tri-state
BUSY  output  1  high in ACTIVE and RELEASE
TIMEOUT_ERR  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Single clock CLK40; reset is asynchronous, active-low, on nRESET.
- Reset state:
  - state = IDLE; channel index, beat count and watchdog all 0.
  - nTA, nTBI and nTEA are Z; BUSY = 0; TIMEOUT_ERR = 0.
- Reset asserted mid-cycle aborts the cycle immediately; pins go to Z with no release cycle.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - All three pins are Z.
  - nTS low with any SPACE_SEL bit set: latch the lowest set index as CH, latch BREQ = (SIZ == 2'b11), clear watchdog and beat count, go to ACTIVE.
  - nTS low with SPACE_SEL all zero: not our cycle; stay in IDLE, pins stay Z.
- ACTIVE:
  - nTA, nTBI and nTEA are driven high unless asserted.
  - SPACE_SEL changes after the start of the cycle are ignored.
  - SRC_ACK bits other than CH are ignored.
- Ack, zero latency:
  - nTA = 0 combinationally in the same cycle SRC_ACK[CH] = 1.
  - On beat 0 only, nTBI = 0 with nTA if !BURST_OK[CH] or SRC_ABORT[CH]. nTBI is never asserted on later beats.
- Burst accept:
  - BURST = BREQ && BURST_OK[CH] && !SRC_ABORT[CH], registered at beat-0 ack.
  - If BURST: the cycle ends on ack number BURST_BEATS.
  - Otherwise: the cycle ends on the first ack.
  - The beat counter is $clog2(BURST_BEATS) bits and increments per ack.
  - On the final ack, go to RELEASE.
- Watchdog:
  - Counter is $clog2(TIMEOUT+1) bits, saturating.
  - Increments each ACTIVE cycle with no ack; cleared on every ack.
  - When count == TIMEOUT: nTEA = 0 and nTA/nTBI = 1 for that cycle, TIMEOUT_ERR = 1 for one cycle, go to RELEASE.
  - If an ack arrives in the same cycle as the timeout, the ack wins: no TEA, counter cleared.
- RELEASE (one cycle):
  - nTA, nTBI and nTEA all driven high, so the next cycle cannot end early; then Z.
  - nTS low with a SPACE_SEL bit set during RELEASE: latch as in IDLE and go directly to ACTIVE; pins stay driven high (back-to-back cycle).
  - Otherwise go to IDLE.
- Never drive a pin low outside ACTIVE. Never assert nTA and nTEA in the same cycle.

Test Plan:
- Single non-burst read, NCH=4: nTS + SPACE_SEL=4'b0010, SIZ=2'b00, BURST_OK[1]=0; ack after 3 cycles -> nTA and nTBI low in the ack cycle, then 1 cycle driven high, then Z; BUSY high for 5 cycles.
- Line burst: SIZ=2'b11, BURST_OK[2]=1, 4 acks spaced 1 cycle apart -> 4 nTA pulses, nTBI never low, RELEASE after the 4th ack.
- Burst inhibited: SIZ=2'b11, BURST_OK=1, SRC_ABORT[2]=1 on beat 0 -> nTA and nTBI low together, cycle ends after 1 beat.
- Timeout, TIMEOUT=8: select CH0, never ack -> nTEA low in the 8th ACTIVE cycle, TIMEOUT_ERR pulses once, nTA stays high.
- Timeout tie: ack arrives exactly when count hits TIMEOUT -> nTA low, nTEA high, no TIMEOUT_ERR.
- Back-to-back and priority:
  - nTS in the RELEASE cycle with SPACE_SEL=4'b1100 -> CH=2, pins never go Z, ACTIVE next cycle.
  - nRESET low mid-burst -> all pins Z immediately, BUSY=0.
  - Unselected nTS -> pins stay Z.
